subdiv_sequencer: RTL
=====================

Name: subdiv_sequencer

Overview:
- Top-level controller for one or more smoothing passes of the subdivision engine.
- Per pass:
  - copies object RAM into result RAM, which the averager requires to be equal at start;
  - pulses the neighbor builder, then the averager, waiting for each to finish;
  - copies the result RAM back into object RAM so the next pass sees the smoothed mesh.
- Owns both RAMs during copy phases and tells the top-level mux who drives them.

Parameters:
ADDR_WIDTH, 9, RAM word address width
ITER_WIDTH, 4, width of iteration count

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  begin a run; sampled only in IDLE
iterations  in  ITER_WIDTH  passes to run; latched at start
vertex_count  in  32  vertices in mesh; latched at start
nbr_busy  in  1  neighbor builder busy
avg_busy  in  1  averager busy
nbr_start  out  1  one-cycle start pulse to neighbor builder
avg_start  out  1  one-cycle start pulse to averager
ram_owner  out  1  1: sequencer drives RAM_OBJ/RAM_RES ports; 0: datapath blocks do
RAM_OBJ_EN, RAM_RES_EN  out  1  RAM enables
RAM_OBJ_A, RAM_RES_A  out  ADDR_WIDTH  word addresses
RAM_OBJ_WE, RAM_RES_WE  out  4  byte write enables
RAM_OBJ_Di, RAM_RES_Di  out  32  write data
RAM_OBJ_Do, RAM_RES_Do  in  32  read data, valid one cycle after address
iter_done  out  ITER_WIDTH  completed passes
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse when run completes

Behaviour:
- Reset: state IDLE; all outputs 0 (EN, WE, A, Di, pulses, busy, done, ram_owner, iter_done).
- Reset mid-run aborts immediately; in-flight writes are dropped.
- Memory layout: vertex v (0-based) occupies words 3v+1..3v+3 (x, y, z). Word 0 is unused. Copy range is 1..3*vertex_count.
- States:
  - IDLE -> COPY_IN on start. Latches iterations and vertex_count, sets busy=1, iter_done=0.
  - If iterations==0 or vertex_count==0: go straight to DONE; no RAM access, no pulses.
- COPY_IN (OBJ->RES), ram_owner=1:
  - Cycle k drives RAM_OBJ_A=k+1, WE=0.
  - Cycle k+1 drives RAM_RES_A=k+1, Di=RAM_OBJ_Do, WE=4'hF.
  - One word per cycle, pipelined. Last write at cycle 3*vertex_count.
  - Then WE=0 and EN=0 on both RAMs, ram_owner=0 -> NBR_RUN.
- NBR_RUN:
  - nbr_start=1 for exactly one cycle, then wait.
  - Must see nbr_busy=1 at least once, then nbr_busy=0 -> AVG_RUN.
  - nbr_busy already high when pulsed counts as "seen".
- AVG_RUN: same handshake with avg_start/avg_busy -> COPY_OUT.
- COPY_OUT (RES->OBJ): mirror of COPY_IN with roles of RAMs swapped; ram_owner=1.
- End of COPY_OUT: iter_done += 1. If iter_done+1 == iterations -> DONE, else -> COPY_IN.
- DONE: done=1 for one cycle, busy=0, ram_owner=0 -> IDLE.
- start while busy: ignored. Latched parameters are not re-sampled mid-run.
- Address width: copy counter truncated to ADDR_WIDTH. 3*vertex_count beyond 2^ADDR_WIDTH-1 is out of contract.
- Pulses never coincide: nbr_start and avg_start are mutually exclusive, and neither is high while ram_owner=1.

Test Plan:
- vertex_count=2, iterations=1; OBJ words 1..6 = 0x10000..0x60000.
  - RES words 1..6 equal OBJ before nbr_start.
  - Copy phase lasts 7 cycles.
  - Exactly one nbr_start, one avg_start, one done.
  - iter_done=1.
- Same mesh, iterations=3, stub averager adds 0x10000 to each RES word.
  - OBJ words end at original+0x30000.
  - Three nbr_start/avg_start pairs; iter_done=3.
- iterations=0, then separately vertex_count=0: done pulses 2 cycles after start; EN/WE never asserted; no start pulses.
- Stub averager holds avg_busy low for 5 cycles after avg_start before rising: sequencer waits until busy rises and falls; COPY_OUT does not start early.
- start re-asserted during AVG_RUN: ignored; latched iterations unchanged; single done at end.
- rst asserted in mid-COPY_IN (cycle 3): next cycle all outputs 0, state IDLE. Fresh start then completes normally.

Source files
------------

// File: rtl/subdiv_sequencer.sv
// Pass controller for the subdivision engine: mirrors object RAM into result RAM,
// runs the neighbor builder and averager, then copies the smoothed mesh back.
module subdiv_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int ITER_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] iterations,
    input  logic [31:0]           vertex_count,
    input  logic                  nbr_busy,
    input  logic                  avg_busy,
    output logic                  nbr_start,
    output logic                  avg_start,
    output logic                  ram_owner,
    output logic                  RAM_OBJ_EN,
    output logic                  RAM_RES_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [ADDR_WIDTH-1:0] RAM_RES_A,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [3:0]            RAM_RES_WE,
    output logic [31:0]           RAM_OBJ_Di,
    output logic [31:0]           RAM_RES_Di,
    input  logic [31:0]           RAM_OBJ_Do,
    input  logic [31:0]           RAM_RES_Do,
    output logic [ITER_WIDTH-1:0] iter_done,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY_IN,
        S_NBR_PULSE,
        S_NBR_WAIT,
        S_AVG_PULSE,
        S_AVG_WAIT,
        S_COPY_OUT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [33:0]           r_cnt;
    logic [33:0]           w_cnt_nxt;
    logic [33:0]           r_words;
    logic [33:0]           w_words_nxt;
    logic [33:0]           w_words_in;
    logic [ITER_WIDTH-1:0] r_iters;
    logic [ITER_WIDTH-1:0] w_iters_nxt;
    logic [ITER_WIDTH-1:0] r_iter_done;
    logic [ITER_WIDTH-1:0] w_iter_done_nxt;
    logic [ITER_WIDTH-1:0] w_iter_inc;
    logic                  r_seen;
    logic                  w_seen_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_copy_last;
    logic                  w_rd_act;
    logic                  w_wr_act;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_wr_addr;

    // Three words per vertex; copy counter k reads word k+1 and writes word k.
    assign w_words_in  = {1'b0, vertex_count, 1'b0} + {2'b00, vertex_count};
    assign w_copy_last = (r_cnt == r_words);
    assign w_rd_act    = (r_cnt < r_words);
    assign w_wr_act    = (r_cnt != 34'd0);
    assign w_rd_addr   = r_cnt[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign w_wr_addr   = r_cnt[ADDR_WIDTH-1:0];
    assign w_iter_inc  = r_iter_done + {{(ITER_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_seen_nxt      = r_seen;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_iter_done_nxt = r_iter_done;
        w_iters_nxt     = r_iters;
        w_words_nxt     = r_words;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_iters_nxt     = iterations;
                    w_words_nxt     = w_words_in;
                    w_busy_nxt      = 1'b1;
                    w_iter_done_nxt = '0;
                    w_cnt_nxt       = '0;
                    if ((iterations == '0) || (vertex_count == 32'd0)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_COPY_IN;
                    end
                end
            end
            S_COPY_IN: begin
                if (w_copy_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_NBR_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt + 34'd1;
                end
            end
            S_NBR_PULSE: begin
                // A builder that is already busy when pulsed counts as having started.
                w_seen_nxt  = nbr_busy;
                w_state_nxt = S_NBR_WAIT;
            end
            S_NBR_WAIT: begin
                if (nbr_busy) begin
                    w_seen_nxt = 1'b1;
                end else if (r_seen) begin
                    w_state_nxt = S_AVG_PULSE;
                end
            end
            S_AVG_PULSE: begin
                w_seen_nxt  = avg_busy;
                w_state_nxt = S_AVG_WAIT;
            end
            S_AVG_WAIT: begin
                if (avg_busy) begin
                    w_seen_nxt = 1'b1;
                end else if (r_seen) begin
                    w_state_nxt = S_COPY_OUT;
                end
            end
            S_COPY_OUT: begin
                if (w_copy_last) begin
                    w_cnt_nxt       = '0;
                    w_iter_done_nxt = w_iter_inc;
                    w_state_nxt     = (w_iter_inc == r_iters) ? S_DONE : S_COPY_IN;
                end else begin
                    w_cnt_nxt = r_cnt + 34'd1;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        nbr_start  = 1'b0;
        avg_start  = 1'b0;
        ram_owner  = 1'b0;
        RAM_OBJ_EN = 1'b0;
        RAM_RES_EN = 1'b0;
        RAM_OBJ_A  = '0;
        RAM_RES_A  = '0;
        RAM_OBJ_WE = 4'h0;
        RAM_RES_WE = 4'h0;
        RAM_OBJ_Di = 32'd0;
        RAM_RES_Di = 32'd0;
        case (r_state)
            S_COPY_IN: begin
                ram_owner  = 1'b1;
                RAM_OBJ_EN = w_rd_act;
                RAM_OBJ_A  = w_rd_act ? w_rd_addr : '0;
                RAM_RES_EN = w_wr_act;
                RAM_RES_A  = w_wr_act ? w_wr_addr : '0;
                RAM_RES_WE = w_wr_act ? 4'hF : 4'h0;
                RAM_RES_Di = w_wr_act ? RAM_OBJ_Do : 32'd0;
            end
            S_COPY_OUT: begin
                ram_owner  = 1'b1;
                RAM_RES_EN = w_rd_act;
                RAM_RES_A  = w_rd_act ? w_rd_addr : '0;
                RAM_OBJ_EN = w_wr_act;
                RAM_OBJ_A  = w_wr_act ? w_wr_addr : '0;
                RAM_OBJ_WE = w_wr_act ? 4'hF : 4'h0;
                RAM_OBJ_Di = w_wr_act ? RAM_RES_Do : 32'd0;
            end
            S_NBR_PULSE: nbr_start = 1'b1;
            S_AVG_PULSE: avg_start = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_seen      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_iter_done <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_seen      <= w_seen_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_iter_done <= w_iter_done_nxt;
        end
    end

    // Run parameters only change on an accepted start, so they need no reset.
    always_ff @(posedge clk) begin
        r_words <= w_words_nxt;
        r_iters <= w_iters_nxt;
    end

    assign iter_done = r_iter_done;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
